// File: rtl/stream_src_rand_if.sv
// Valid/ready stream bundle for stream_src_rand: valid, ready, last, data.
interface stream_src_rand_if #(
  parameter int DATA_W = 8
) ();
  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;

  modport master (output valid, output last, output data, input ready);
  modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/stream_src_rand.sv
// Pseudo-random valid/ready stream source with packetised beats.
// A single 32-bit Galois LFSR, stepped once per beat draw, supplies the
// random data and inter-beat gaps, so a run is repeatable from SEED.
// Optional macro SRC_RAND_STATS_EN adds saturating pkt_cnt/stall_cnt outputs.
//
// state  | meaning
// IDLE   | no packet active; waits for en to start one
// GAP    | beat drawn; counting down random idle cycles before it is offered
// SEND   | valid=1; beat held until the sink takes it
module stream_src_rand #(
  parameter int          DATA_W    = 8,
  parameter int          DELAY_W   = 3,
  parameter int          PKT_LEN_W = 4,
  parameter logic [31:0] SEED      = 32'hACE12345
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [PKT_LEN_W-1:0] pkt_len,
  stream_src_rand_if.master    src
`ifdef SRC_RAND_STATS_EN
  ,
  output logic [15:0]          pkt_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  localparam logic [31:0]          SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0]          TAPS     = 32'h80200003;
  localparam logic [PKT_LEN_W-1:0] LEN_ONE  = PKT_LEN_W'(1);
  localparam logic [DELAY_W-1:0]   GAP_ONE  = DELAY_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_SEND} state_t;

  state_t               state_q, state_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [DATA_W-1:0]    inc_q, inc_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [PKT_LEN_W-1:0] idx_q, idx_d;
  logic [PKT_LEN_W-1:0] len_q, len_d;
  logic [1:0]           mode_q, mode_d;
  logic [DELAY_W-1:0]   gap_q, gap_d;

  logic [31:0]          lfsr_step;
  logic                 handshake;
  logic                 is_last;
  logic                 start;
  logic                 draw;
  logic [1:0]           draw_mode;
  logic [DATA_W-1:0]    draw_data;
  logic [DELAY_W-1:0]   draw_gap;

  // Beat draw: a new packet takes mode from the input, later beats from the latch.
  always_comb begin
    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    handshake = (state_q == S_SEND) && src.ready;
    is_last   = (idx_q == (len_q - LEN_ONE));
    start     = ((state_q == S_IDLE) && en) || (handshake && is_last && en);
    draw      = start || (handshake && !is_last);
    draw_mode = start ? mode : mode_q;
    draw_data = draw_mode[0] ? inc_q : lfsr_step[DATA_W-1:0];
    draw_gap  = draw_mode[1] ? '0 : lfsr_step[31 -: DELAY_W];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (draw) state_d = (draw_gap == '0) ? S_SEND : S_GAP;
      S_GAP:  if (gap_q == GAP_ONE) state_d = S_SEND;
      S_SEND: begin
        if (draw)           state_d = (draw_gap == '0) ? S_SEND : S_GAP;
        else if (handshake) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: LFSR, counters and beat registers change only on a draw.
  always_comb begin
    lfsr_d = lfsr_q;
    inc_d  = inc_q;
    data_d = data_q;
    idx_d  = idx_q;
    len_d  = len_q;
    mode_d = mode_q;
    gap_d  = gap_q;
    if (state_q == S_GAP) gap_d = gap_q - GAP_ONE;
    if (draw) begin
      lfsr_d = lfsr_step;
      inc_d  = inc_q + DATA_W'(1);
      data_d = draw_data;
      gap_d  = draw_gap;
      idx_d  = idx_q + LEN_ONE;
    end
    if (start) begin
      mode_d = mode;
      len_d  = (pkt_len == '0) ? LEN_ONE : pkt_len;
      idx_d  = '0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      inc_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      len_q   <= LEN_ONE;
      mode_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      inc_q   <= inc_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      gap_q   <= gap_d;
    end
  end

  // Stream outputs decoded from state; last is qualified by valid.
  always_comb begin
    src.valid = (state_q == S_SEND);
    src.last  = (state_q == S_SEND) && is_last;
    src.data  = data_q;
  end

`ifdef SRC_RAND_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters: completed packets and stalled valid cycles.
  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (handshake && is_last && (pkt_cnt_q != 16'hFFFF))
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    if ((state_q == S_SEND) && !src.ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stream_src_rand.sv
// Directed bench for stream_src_rand; beat values come from a reference LFSR draw model.
module tb_stream_src_rand;
  localparam int          DATA_W    = 8;
  localparam int          DELAY_W   = 3;
  localparam int          PKT_LEN_W = 4;
  localparam logic [31:0] SEED      = 32'hACE12345;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [1:0]           mode;
  logic [PKT_LEN_W-1:0] pkt_len;
`ifdef SRC_RAND_STATS_EN
  logic [15:0]          pkt_cnt;
  logic [15:0]          stall_cnt;
`endif

  stream_src_rand_if #(.DATA_W(DATA_W)) bus ();

  stream_src_rand #(
    .DATA_W(DATA_W), .DELAY_W(DELAY_W), .PKT_LEN_W(PKT_LEN_W), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .pkt_len(pkt_len), .src(bus)
`ifdef SRC_RAND_STATS_EN
    , .pkt_cnt(pkt_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int                nvec = 0;
  int                nerr = 0;
  logic [31:0]       m_lfsr;
  logic [DATA_W-1:0] m_inc;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_draw(input logic [1:0] md, output logic [DATA_W-1:0] d, output int g);
    logic [31:0] v;
    m_lfsr = lfsr_next(m_lfsr);
    v = m_lfsr;
    d = md[0] ? m_inc : v[DATA_W-1:0];
    g = md[1] ? 0 : int'(v[31 -: DELAY_W]);
    m_inc = m_inc + 1'b1;
  endtask

  // Called at the negedge just after the edge on which the DUT drew this beat.
  task automatic do_beat(input logic [1:0] md, input bit exp_last, input int stall, input string tag);
    logic [DATA_W-1:0] d;
    int g;
    model_draw(md, d, g);
    for (int i = 0; i < g; i++) begin
      chk({tag, " gap_valid"}, 32'(bus.valid), 32'(0));
      @(posedge clk); @(negedge clk);
    end
    chk({tag, " valid"}, 32'(bus.valid), 32'(1));
    chk({tag, " data"}, 32'(bus.data), 32'(d));
    chk({tag, " last"}, 32'(bus.last), 32'(exp_last));
    for (int s = 0; s < stall; s++) begin
      bus.ready = 1'b0;
      @(posedge clk); @(negedge clk);
      chk({tag, " stall_valid"}, 32'(bus.valid), 32'(1));
      chk({tag, " stall_data"}, 32'(bus.data), 32'(d));
      chk({tag, " stall_last"}, 32'(bus.last), 32'(exp_last));
    end
    bus.ready = 1'b1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; bus.ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst valid", 32'(bus.valid), 32'(0));
    chk("rst last", 32'(bus.last), 32'(0));
    chk("rst data", 32'(bus.data), 32'(0));
`ifdef SRC_RAND_STATS_EN
    chk("rst pkt_cnt", 32'(pkt_cnt), 32'(0));
`endif
    rst = 1'b0;
    m_lfsr = SEED;
    m_inc  = '0;
  endtask

  task automatic start(input logic [1:0] md, input logic [PKT_LEN_W-1:0] len);
    en = 1'b1; mode = md; pkt_len = len;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " idle_valid"}, 32'(bus.valid), 32'(0));
    @(posedge clk); @(negedge clk);
    chk({tag, " idle_valid2"}, 32'(bus.valid), 32'(0));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; pkt_len = '0; bus.ready = 1'b1;
    do_reset();

    // Incrementing data, zero gap, 4-beat packets, back to back.
    start(2'b11, 4'd4);
    for (int k = 0; k < 12; k++) begin
      if (k == 11) en = 1'b0;
      do_beat(2'b11, (k % 4) == 3, 0, "A");
    end
    idle_chk("A");

    // Incrementing data, random gap, single-beat packets, ready toggling.
    start(2'b01, 4'd1);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) en = 1'b0;
      do_beat(2'b01, 1'b1, k % 2, "B");
    end
    idle_chk("B");

    // Random data/gap from SEED: ready always high, then random ready.
    do_reset();
    start(2'b00, 4'd3);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) en = 1'b0;
      do_beat(2'b00, (k % 3) == 2, 0, "C1");
    end
    idle_chk("C1");
    do_reset();
    start(2'b00, 4'd3);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) en = 1'b0;
      do_beat(2'b00, (k % 3) == 2, int'($urandom_range(0, 2)), "C2");
    end
    idle_chk("C2");

    // pkt_len boundaries: 0 behaves as 1, 15 puts last on beat 15 only.
    start(2'b11, 4'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) en = 1'b0;
      do_beat(2'b11, 1'b1, 0, "D0");
    end
    idle_chk("D0");
    start(2'b11, 4'd15);
    for (int k = 0; k < 15; k++) begin
      if (k == 14) en = 1'b0;
      do_beat(2'b11, k == 14, 0, "D15");
    end
    idle_chk("D15");

    // en dropped mid-packet: the packet still completes.
    start(2'b11, 4'd6);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) en = 1'b0;
      do_beat(2'b11, k == 5, 0, "E");
    end
    idle_chk("E");

    // mode/pkt_len changed mid-packet: only the next packet sees them.
    start(2'b11, 4'd3);
    do_beat(2'b11, 1'b0, 0, "M0");
    mode = 2'b10; pkt_len = 4'd2;
    do_beat(2'b11, 1'b0, 0, "M0");
    do_beat(2'b11, 1'b1, 0, "M0");
    do_beat(2'b10, 1'b0, 0, "M1");
    en = 1'b0;
    do_beat(2'b10, 1'b1, 0, "M1");
    idle_chk("M1");

    // Async reset while a beat is stalled.
    do_reset();
    start(2'b11, 4'd4);
    chk("F valid", 32'(bus.valid), 32'(1));
    chk("F data", 32'(bus.data), 32'(0));
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
    end
`ifdef SRC_RAND_STATS_EN
    chk("F stall_cnt", 32'(stall_cnt), 32'(3));
`endif
    #2 rst = 1'b1;
    #1;
    chk("F async_valid", 32'(bus.valid), 32'(0));
    chk("F async_last", 32'(bus.last), 32'(0));
    chk("F async_data", 32'(bus.data), 32'(0));
`ifdef SRC_RAND_STATS_EN
    chk("F async_stall_cnt", 32'(stall_cnt), 32'(0));
    chk("F async_pkt_cnt", 32'(pkt_cnt), 32'(0));
`endif
    @(negedge clk);
    rst = 1'b0; en = 1'b0; bus.ready = 1'b1;
    m_lfsr = SEED;
    m_inc  = '0;
    start(2'b00, 4'd2);
    do_beat(2'b00, 1'b0, 0, "F2");
    en = 1'b0;
    do_beat(2'b00, 1'b1, 0, "F2");
    idle_chk("F2");
`ifdef SRC_RAND_STATS_EN
    chk("F2 pkt_cnt", 32'(pkt_cnt), 32'(1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/stream_src_rand.md
Name: stream_src_rand

Overview:
- Parametrised pseudo-random valid/ready stream source for testbenches and on-chip self-test.
- Drives a sink with beats separated by random inter-beat gaps; groups beats into packets of programmable length with a proper last flag.
- Synthesisable: a 32-bit LFSR supplies all randomness, so runs are reproducible from SEED.

Parameters:
DATA_W, 8, data width in bits, legal 1..32
DELAY_W, 3, gap field width; gap range 0..2^DELAY_W-1 cycles, legal 1..8
PKT_LEN_W, 4, width of pkt_len input
SEED, 32'hACE12345, LFSR reset value; 0 is replaced by 32'h1

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
en  in  1  generation enable, sampled only at packet boundaries
mode  in  2  00 random data/random gap, 01 incrementing data/random gap, 10 random data/zero gap, 11 incrementing data/zero gap
pkt_len  in  PKT_LEN_W  beats per packet; 0 treated as 1
ready  in  1  sink ready
valid  out  1  beat valid
last  out  1  final beat of packet, qualified by valid
data  out  DATA_W  beat payload

Behaviour:
- Reset (async, active-high): valid=0, last=0, data=0, lfsr=SEED (or 1), inc counter=0, beat index=0, state=IDLE. Takes effect immediately; any beat in flight is dropped.
- LFSR: 32-bit Galois, taps 32'h80200003. Advances exactly once per beat draw, never on idle cycles. The output sequence is therefore independent of ready timing.
- Draw for each beat:
  - data = lfsr[DATA_W-1:0] (random modes) or inc counter (increment modes).
  - gap = lfsr[31:32-DELAY_W], forced to 0 in modes 1x.
  - The inc counter increments per beat, wraps modulo 2^DATA_W, and is not cleared by packets.
- FSM states IDLE, GAP, SEND.
  - IDLE: valid=0. If en=1: latch mode and pkt_len (0 becomes 1), beat index=0, draw beat, go to GAP (gap>0) or SEND (gap=0).
  - GAP: valid=0; count gap cycles down; at 0 go to SEND. A gap of N gives exactly N cycles with valid=0 between beats.
  - SEND: valid=1. data and last are held stable while ready=0; no drop or change is permitted.
  - last = (beat index == latched pkt_len-1).
- Handshake in SEND (valid & ready):
  - If not last: index+1, draw next beat, go to GAP or SEND. With gap=0, valid stays high back-to-back.
  - If last: packet done. If en=1, start a new packet as in IDLE with no bubble when gap=0. If en=0, go to IDLE.
- en deassertion mid-packet does not truncate the packet; the packet completes.
- mode and pkt_len changes mid-packet are ignored until the next packet start.
- Throughput: in modes 1x with ready=1, one beat per cycle. First valid appears 1 cycle after en is seen high in IDLE (gap=0).

Optional Feature:
- Macro SRC_RAND_STATS_EN.
- Defined: adds outputs pkt_cnt[15:0] (completed packets) and stall_cnt[15:0] (cycles with valid=1, ready=0). Both saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then en=1, mode=11, pkt_len=4, ready=1 -> data 0,1,2,3,4,... one per cycle; last on every 4th beat (data 3,7,11); valid never drops.
- mode=01, pkt_len=1, ready toggling 1/0 -> data and last stable across every ready=0 cycle; gaps match the LFSR-predicted values; last=1 on every beat.
- Same SEED, mode=00, two runs with ready=1 vs random ready -> identical data and gap sequences (first data = model of lfsr after one step), only timing differs.
- pkt_len=0, mode=11 -> every beat has last=1; pkt_len=15 -> last on beat 15 only.
- en dropped at beat 2 of a 6-beat packet -> beats 3..5 still sent; last on beat 5; then IDLE with valid=0. Change mode mid-packet -> takes effect on the next packet only.
- rst asserted while valid=1 and ready=0 -> valid=0 immediately (same cycle, async). After release, data sequence restarts from SEED. With SRC_RAND_STATS_EN, stall_cnt=3 after 3 stalled cycles and pkt_cnt=0 after reset.
